fu_cfg_sequencer: RTL and testbench

Programmable configuration sequencer for the PE functional-unit cluster (CMAC/DMEM/logical/CORDIC/FIFO). It holds a small program of cluster configuration words, each with a per-entry repeat count. On start it drives config_o through the entries, holding each one for rep+1 cycles, and loops the whole program a set number of times. It sits between the PE control/host load path and the config_all input of the FU cluster.

---
 rtl/fu_cfg_sequencer.sv | 157 +++++++++++++++
 tb/tb_fu_cfg_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_cfg_sequencer.sv
// rtl/fu_cfg_sequencer.sv - programmable configuration sequencer for the PE FU cluster
//
// Plays a small program of cluster configuration words onto config_o. Each
// entry is held for rep+1 cycles, and the whole program is replayed
// loop_cnt+1 times.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   prog_we/addr    program write strobe and entry address (IDLE only)
//   prog_cfg/rep    config word and repeat count written to the entry
//   start           start-run pulse; num_instr/loop_cnt are sampled with it
//   num_instr       program length, 1..DEPTH
//   loop_cnt        extra passes over the program
//   stall           freeze sequencing for this cycle
//   abort           end the run, return to IDLE without a done pulse
//   config_o        registered config word to the FU cluster
//   config_valid_o  config_o is live this cycle
//   pc_o            current entry index
//   busy_o          run in progress (RUN or FINISH)
//   done_o          one-cycle completion pulse
module fu_cfg_sequencer #(
  parameter int CONFIG_ALL = 64,
  parameter int DEPTH      = 16,
  parameter int REP_W      = 8,
  parameter int LOOP_W     = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [CONFIG_ALL-1:0] prog_cfg,
  input  logic [REP_W-1:0]      prog_rep,
  input  logic                  start,
  input  logic [AW:0]           num_instr,
  input  logic [LOOP_W-1:0]     loop_cnt,
  input  logic                  stall,
  input  logic                  abort,
  output logic [CONFIG_ALL-1:0] config_o,
  output logic                  config_valid_o,
  output logic [AW-1:0]         pc_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [AW:0] MAX_INSTR = (AW+1)'(DEPTH);

  logic [CONFIG_ALL-1:0] mem_cfg [DEPTH];
  logic [REP_W-1:0]      mem_rep [DEPTH];

  state_t                state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [AW-1:0]         last_q, last_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic [LOOP_W-1:0]     loops_q, loops_d;
  logic [CONFIG_ALL-1:0] cfg_q, cfg_d;

  logic                  num_ok;
  logic [AW:0]           num_m1;
  logic [AW-1:0]         pc_inc;

  assign num_ok = (num_instr != '0) && (num_instr <= MAX_INSTR);
  assign num_m1 = num_instr - 1'b1;
  assign pc_inc = pc_q + 1'b1;

  // Program store; reset clears every entry so a run after reset sees zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_cfg[i] <= '0;
        mem_rep[i] <= '0;
      end
    end else if (prog_we && state_q == ST_IDLE) begin
      mem_cfg[prog_addr] <= prog_cfg;
      mem_rep[prog_addr] <= prog_rep;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      loops_q <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      loops_q <= loops_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    rep_d   = rep_q;
    loops_d = loops_q;
    cfg_d   = cfg_q;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous program write takes precedence over start.
        if (start && !prog_we && num_ok) begin
          state_d = ST_RUN;
          last_d  = num_m1[AW-1:0];
          loops_d = loop_cnt;
          pc_d    = '0;
          rep_d   = mem_rep[0];
          cfg_d   = mem_cfg[0];
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          if (rep_q != '0) begin
            rep_d = rep_q - 1'b1;
          end else if (pc_q != last_q) begin
            pc_d  = pc_inc;
            rep_d = mem_rep[pc_inc];
            cfg_d = mem_cfg[pc_inc];
          end else if (loops_q != '0) begin
            loops_d = loops_q - 1'b1;
            pc_d    = '0;
            rep_d   = mem_rep[0];
            cfg_d   = mem_cfg[0];
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign config_o       = cfg_q;
  assign pc_o           = pc_q;
  assign config_valid_o = (state_q == ST_RUN) && !stall;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_FINISH);

endmodule

// File: tb/tb_fu_cfg_sequencer.sv
// tb/tb_fu_cfg_sequencer.sv - self-checking bench for fu_cfg_sequencer
module tb_fu_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [63:0] prog_cfg;
  logic [7:0]  prog_rep;
  logic        start;
  logic [4:0]  num_instr;
  logic [7:0]  loop_cnt;
  logic        stall;
  logic        abort;
  logic [63:0] config_o;
  logic        config_valid_o;
  logic [3:0]  pc_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] CFG_A = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] CFG_B = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] CFG_C = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] CFG_D = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] CFG_X = 64'hDEAD_BEEF_0000_0005;

  fu_cfg_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_cfg       (prog_cfg),
    .prog_rep       (prog_rep),
    .start          (start),
    .num_instr      (num_instr),
    .loop_cnt       (loop_cnt),
    .stall          (stall),
    .abort          (abort),
    .config_o       (config_o),
    .config_valid_o (config_valid_o),
    .pc_o           (pc_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is the flat list of (entry, cfg) words that
  // must appear on valid cycles, expanded from the shadow program.
  typedef struct packed {
    logic [3:0]  pc;
    logic [63:0] cfg;
  } ent_t;

  ent_t        q[$];
  int          m_phase;   // 0 idle, 1 run, 2 finish
  logic [63:0] m_cfg;
  logic [3:0]  m_pc;
  logic [63:0] sh_cfg [16];
  logic [7:0]  sh_rep [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_cfg   = '0;
      m_pc    = '0;
      q.delete();
      for (int i = 0; i < 16; i++) begin
        sh_cfg[i] = '0;
        sh_rep[i] = '0;
      end
    end else begin
      case (m_phase)
        0: begin
          if (prog_we) begin
            sh_cfg[prog_addr] = prog_cfg;
            sh_rep[prog_addr] = prog_rep;
          end else if (start && num_instr >= 1 && num_instr <= 16) begin
            q.delete();
            for (int l = 0; l <= int'(loop_cnt); l++)
              for (int i = 0; i < int'(num_instr); i++)
                for (int r = 0; r <= int'(sh_rep[i]); r++)
                  q.push_back({4'(i), sh_cfg[i]});
            m_phase = 1;
            m_pc    = q[0].pc;
            m_cfg   = q[0].cfg;
          end
        end
        1: begin
          if (abort) begin
            m_phase = 0;
            q.delete();
          end else if (!stall) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
              m_phase = 2;
            end else begin
              m_pc  = q[0].pc;
              m_cfg = q[0].cfg;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", config_valid_o, (m_phase == 1) && !stall);
      chk("m_busy",  busy_o,         m_phase != 0);
      chk("m_done",  done_o,         m_phase == 2);
      chk("m_cfg",   config_o,       m_cfg);
      chk("m_pc",    pc_o,           m_pc);
    end
  end

  // Hand-computed cycle tables, index k = cycles after the start edge.
  logic        lv [1:16];
  logic [63:0] lc [1:16];
  logic [3:0]  lp [1:16];
  logic        ld [1:16];
  logic        ls [1:16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int k = 1; k <= 16; k++) begin
      lv[k] = 1'b0; lc[k] = '0; lp[k] = '0; ld[k] = 1'b0; ls[k] = 1'b0;
    end
  endtask

  task automatic set_exp(input int k, input logic [63:0] c, input logic [3:0] p);
    lv[k] = 1'b1;
    lc[k] = c;
    lp[k] = p;
  endtask

  task automatic prog(input logic [3:0] a, input logic [63:0] c, input logic [7:0] r);
    prog_we = 1'b1; prog_addr = a; prog_cfg = c; prog_rep = r;
    step();
    prog_we = 1'b0;
  endtask

  task automatic launch(input logic [4:0] n, input logic [7:0] lc_in);
    num_instr = n; loop_cnt = lc_in; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_seq(input string nm, input int n);
    for (int k = 1; k <= n; k++) begin
      stall = ls[k];
      @(negedge clk);
      chk({nm, "_valid"}, config_valid_o, lv[k]);
      chk({nm, "_done"},  done_o,         ld[k]);
      if (lv[k]) begin
        chk({nm, "_cfg"}, config_o, lc[k]);
        chk({nm, "_pc"},  pc_o,     lp[k]);
      end
      step();
    end
    stall = 1'b0;
  endtask

  task automatic set_abbbcc(input int base);
    set_exp(base + 0, CFG_A, 4'd0);
    set_exp(base + 1, CFG_B, 4'd1);
    set_exp(base + 2, CFG_B, 4'd1);
    set_exp(base + 3, CFG_B, 4'd1);
    set_exp(base + 4, CFG_C, 4'd2);
    set_exp(base + 5, CFG_C, 4'd2);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_cfg = '0; prog_rep = '0;
    start = 1'b0; num_instr = '0; loop_cnt = '0; stall = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, then idle with no start.
    @(negedge clk);
    chk("rst_cfg",   config_o,       64'd0);
    chk("rst_valid", config_valid_o, 1'b0);
    chk("rst_busy",  busy_o,         1'b0);
    chk("rst_done",  done_o,         1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("idle_cfg",  config_o,       64'd0);
    chk("idle_busy", busy_o,         1'b0);
    step();

    // Single pass: A rep0, B rep2, C rep1.
    prog(4'd0, CFG_A, 8'd0);
    prog(4'd1, CFG_B, 8'd2);
    prog(4'd2, CFG_C, 8'd1);
    clear_exp();
    set_abbbcc(1);
    ld[7] = 1'b1;
    launch(5'd3, 8'd0);
    run_seq("single", 8);
    @(negedge clk);
    chk("single_idle_busy", busy_o, 1'b0);
    step();

    // Two passes.
    clear_exp();
    set_abbbcc(1);
    set_abbbcc(7);
    ld[13] = 1'b1;
    launch(5'd3, 8'd1);
    run_seq("loop", 14);

    // Stall two cycles on a single-entry program, rep3.
    prog(4'd0, CFG_D, 8'd3);
    clear_exp();
    set_exp(1, CFG_D, 4'd0);
    ls[2] = 1'b1;
    ls[3] = 1'b1;
    set_exp(4, CFG_D, 4'd0);
    set_exp(5, CFG_D, 4'd0);
    set_exp(6, CFG_D, 4'd0);
    ld[7] = 1'b1;
    launch(5'd1, 8'd0);
    run_seq("stall", 8);

    // Abort mid-run, with a write attempted during the run.
    prog(4'd0, CFG_A, 8'd0);
    launch(5'd3, 8'd0);
    @(negedge clk);
    chk("abort_k1_cfg", config_o, CFG_A);
    step();
    prog_we = 1'b1; prog_addr = 4'd1; prog_cfg = CFG_X; prog_rep = 8'd5;
    @(negedge clk);
    chk("abort_k2_cfg", config_o, CFG_B);
    step();
    prog_we = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_k3_valid", config_valid_o, 1'b1);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_k4_busy",  busy_o,         1'b0);
    chk("abort_k4_valid", config_valid_o, 1'b0);
    chk("abort_k4_done",  done_o,         1'b0);
    chk("abort_k4_cfg",   config_o,       CFG_B);
    step();
    @(negedge clk);
    chk("abort_k5_done", done_o, 1'b0);
    step();

    // Entry 1 must be unchanged by the write during the run.
    clear_exp();
    set_abbbcc(1);
    ld[7] = 1'b1;
    launch(5'd3, 8'd0);
    run_seq("after_abort", 8);

    // Ignored starts.
    launch(5'd0, 8'd0);
    @(negedge clk);
    chk("start_n0_busy", busy_o, 1'b0);
    step();
    launch(5'd17, 8'd0);
    @(negedge clk);
    chk("start_n17_busy", busy_o, 1'b0);
    step();
    prog_we = 1'b1; prog_addr = 4'd3; prog_cfg = CFG_D; prog_rep = 8'd0;
    launch(5'd3, 8'd0);
    prog_we = 1'b0;
    @(negedge clk);
    chk("start_we_busy", busy_o, 1'b0);
    step();

    // Asynchronous reset between clock edges during a run.
    launch(5'd3, 8'd0);
    step();
    @(negedge clk);
    chk("arst_pre_cfg", config_o, CFG_B);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_cfg",   config_o,       64'd0);
    chk("arst_valid", config_valid_o, 1'b0);
    chk("arst_busy",  busy_o,         1'b0);
    chk("arst_pc",    pc_o,           4'd0);
    chk("arst_done",  done_o,         1'b0);
    step();
    rst = 1'b0;
    step();

    // Cleared program: three entries of cfg 0, rep 0.
    clear_exp();
    set_exp(1, 64'd0, 4'd0);
    set_exp(2, 64'd0, 4'd1);
    set_exp(3, 64'd0, 4'd2);
    ld[4] = 1'b1;
    launch(5'd3, 8'd0);
    run_seq("post_rst", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
